// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB destinations and stalls IF/ID on RAW hazards.
// Optional macro FORWARDING_EN: only load-use hazards against EX stall (EX/MEM forwarding present).
module hazard_scoreboard #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       src1_reg,
    input  logic             src1_used,
    input  logic [2:0]       src2_reg,
    input  logic             src2_used,
    input  logic [2:0]       dest_reg,
    input  logic             dest_valid,
    input  logic             is_load,
    input  logic             flush,
    input  logic             pipe_hold,
    output logic             stall,
    output logic [7:0]       inflight,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef FORWARDING_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif
    localparam bit WbCheck = (WB_BYPASS == 0);
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Only the EX slot's load flag is ever consulted, so S1/S2 do not carry it.
    logic       s0_v_q, s1_v_q, s2_v_q;
    logic [2:0] s0_reg_q, s1_reg_q, s2_reg_q;
    logic       s0_ld_q;
    logic       s0_v_d, s1_v_d, s2_v_d;
    logic [2:0] s0_reg_d, s1_reg_d, s2_reg_d;
    logic       s0_ld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic m0, m1, m2, hz;

    function automatic logic slot_match(input logic v, input logic [2:0] slot_reg);
        return v & ((src1_used & (slot_reg == src1_reg)) |
                    (src2_used & (slot_reg == src2_reg)));
    endfunction

    always_comb begin
        m0 = slot_match(s0_v_q, s0_reg_q);
        m1 = slot_match(s1_v_q, s1_reg_q);
        m2 = slot_match(s2_v_q, s2_reg_q);
        hz = (m0 & (s0_ld_q | !FwdEn)) | (!FwdEn & m1) | (!FwdEn & WbCheck & m2);
        stall = id_valid & !flush & (hz | pipe_hold);
    end

    always_comb begin
        inflight = 8'h00;
        if (s0_v_q) inflight[s0_reg_q] = 1'b1;
        if (s1_v_q) inflight[s1_reg_q] = 1'b1;
        if (s2_v_q) inflight[s2_reg_q] = 1'b1;
    end

    always_comb begin
        s0_v_d   = s0_v_q;
        s0_reg_d = s0_reg_q;
        s0_ld_d  = s0_ld_q;
        s1_v_d   = s1_v_q;
        s1_reg_d = s1_reg_q;
        s2_v_d   = s2_v_q;
        s2_reg_d = s2_reg_q;
        if (!pipe_hold) begin
            s2_v_d   = s1_v_q;
            s2_reg_d = s1_reg_q;
            s1_v_d   = s0_v_q;
            s1_reg_d = s0_reg_q;
            if (flush || stall || !id_valid) begin
                s0_v_d = 1'b0;
            end else begin
                s0_v_d   = dest_valid;
                s0_reg_d = dest_reg;
                s0_ld_d  = is_load;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s0_reg_q    <= 3'd0;
            s1_reg_q    <= 3'd0;
            s2_reg_q    <= 3'd0;
            s0_ld_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            s0_v_q      <= s0_v_d;
            s1_v_q      <= s1_v_d;
            s2_v_q      <= s2_v_d;
            s0_reg_q    <= s0_reg_d;
            s1_reg_q    <= s1_reg_d;
            s2_reg_q    <= s2_reg_d;
            s0_ld_q     <= s0_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
